// File: rtl/bus_mem_slave.sv
// Word-addressed RAM slave with programmable wait states and held read response.
// Optional misaligned-access rejection is enabled by defining BUS_MEM_ALIGN_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for BUS_valid, request captured on acceptance
// WAIT    | counting down wait states, commit/read on terminal count
// WRESP   | one-cycle BUS_wready pulse
// RRESP   | BUS_rvalid held until BUS_rready
// RELEASE | waiting for BUS_valid to drop before the next request
module bus_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  BUS_valid,
  input  logic                  BUS_mode,
  input  logic [ADDR_WIDTH-1:0] BUS_addr,
  input  logic [DATA_WIDTH-1:0] BUS_wdata,
  output logic                  BUS_wready,
  output logic [DATA_WIDTH-1:0] BUS_rdata,
  output logic                  BUS_rvalid,
  input  logic                  BUS_rready,
  output logic                  busy,
  output logic                  err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DATA_WIDTH-1:0] REJECT_DATA = DATA_WIDTH'(32'hDEADBEEF);

`ifdef BUS_MEM_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK = 1'b1;
`else
  localparam logic ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WRESP,
    S_RRESP,
    S_RELEASE
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    mode_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    bad_q;
  logic                    err_q;
  logic                    addr_bad;
  logic                    mem_we;
  logic                    unused_addr;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign addr_bad = ALIGN_CHECK && (BUS_addr[1:0] != 2'b00);
  assign mem_we   = (state == S_WAIT) && (cnt == 4'd0) && mode_q && !bad_q;
  assign err      = err_q;

  // Upper address bits alias; they are deliberately left undecoded.
  generate
    if (ADDR_WIDTH > DEPTH_LOG2 + 2) begin : g_unused_hi
      assign unused_addr = ^BUS_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
    end else begin : g_no_hi
      assign unused_addr = 1'b0;
    end
  endgenerate

  // Array has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      mode_q     <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      bad_q      <= 1'b0;
      err_q      <= 1'b0;
      BUS_wready <= 1'b0;
      BUS_rvalid <= 1'b0;
      BUS_rdata  <= '0;
      busy       <= 1'b0;
    end else begin
      BUS_wready <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (BUS_valid) begin
            mode_q  <= BUS_mode;
            idx_q   <= BUS_addr[DEPTH_LOG2+1:2];
            wdata_q <= BUS_wdata;
            bad_q   <= addr_bad;
            cnt     <= 4'(LATENCY);
            busy    <= 1'b1;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (mode_q) begin
            BUS_wready <= 1'b1;
            err_q      <= bad_q;
            state      <= S_WRESP;
          end else begin
            BUS_rdata  <= bad_q ? REJECT_DATA : mem[idx_q];
            BUS_rvalid <= 1'b1;
            err_q      <= bad_q;
            state      <= S_RRESP;
          end
        end
        S_WRESP: begin
          state <= S_RELEASE;
        end
        S_RRESP: begin
          if (BUS_rready) begin
            BUS_rvalid <= 1'b0;
            state      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!BUS_valid) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_slave.sv
// Scoreboard bench for bus_mem_slave: stimulus queues expected responses, a monitor checks them.
// Define BUS_MEM_ALIGN_CHECK_EN for both files to exercise misaligned-access rejection.
module tb_bus_mem_slave;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        BUS_valid = 1'b0;
  logic        BUS_mode = 1'b0;
  logic [31:0] BUS_addr = '0;
  logic [31:0] BUS_wdata = '0;
  logic        BUS_wready;
  logic [31:0] BUS_rdata;
  logic        BUS_rvalid;
  logic        BUS_rready = 1'b0;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rv_prev = 1'b0;

  typedef struct {
    bit          wr;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  bus_mem_slave #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH_LOG2(10),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .BUS_valid(BUS_valid),
    .BUS_mode(BUS_mode),
    .BUS_addr(BUS_addr),
    .BUS_wdata(BUS_wdata),
    .BUS_wready(BUS_wready),
    .BUS_rdata(BUS_rdata),
    .BUS_rvalid(BUS_rvalid),
    .BUS_rready(BUS_rready),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: pops one expected item per response and checks kind, timing, data and err.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (BUS_wready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_wready", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk(e.wr, "resp_kind_write", 32'd1, {31'd0, e.wr});
          chk(cyc == e.cyc, "wready_cycle", cyc, e.cyc);
          chk(err == e.err, "write_err", {31'd0, err}, {31'd0, e.err});
        end
      end
      if (BUS_rvalid && !rv_prev) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk(!e.wr, "resp_kind_read", 32'd0, {31'd0, e.wr});
          chk(cyc == e.cyc, "rvalid_cycle", cyc, e.cyc);
          chk(BUS_rdata === e.data, "read_data", BUS_rdata, e.data);
          chk(err == e.err, "read_err", {31'd0, err}, {31'd0, e.err});
        end
      end
      if (err && !BUS_wready && !(BUS_rvalid && !rv_prev))
        chk(1'b0, "stray_err", 32'd1, 32'd0);
      rv_prev = BUS_rvalid;
    end else begin
      rv_prev = 1'b0;
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input bit exp_err, input int hold);
    exp_t e;
    int n;
    e.wr = 1'b1; e.data = data; e.err = exp_err; e.cyc = cyc + 2 + LAT;
    sb.push_back(e);
    BUS_valid = 1'b1; BUS_mode = 1'b1; BUS_addr = addr; BUS_wdata = data;
    @(posedge clk); #1;
    BUS_wdata = ~data; BUS_addr = addr ^ 32'h10; BUS_mode = 1'b0;
    n = 0;
    while (!BUS_wready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(BUS_wready, "wready_timeout", {31'd0, BUS_wready}, 32'd1);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk(!BUS_wready && busy, "release_hold", {30'd0, BUS_wready, busy}, 32'd1);
    end
    BUS_valid = 1'b0;
    @(posedge clk); #1;
    chk(!busy, "busy_after_write", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input bit exp_err, input int stall);
    exp_t e;
    int n;
    e.wr = 1'b0; e.data = exp_data; e.err = exp_err; e.cyc = cyc + 2 + LAT;
    sb.push_back(e);
    BUS_valid = 1'b1; BUS_mode = 1'b0; BUS_addr = addr; BUS_rready = 1'b0;
    @(posedge clk); #1;
    BUS_addr = addr ^ 32'h10; BUS_mode = 1'b1; BUS_wdata = 32'hFFFF_FFFF;
    n = 0;
    while (!BUS_rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(BUS_rvalid, "rvalid_timeout", {31'd0, BUS_rvalid}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk(BUS_rvalid && (BUS_rdata === exp_data), "stall_stable", BUS_rdata, exp_data);
    end
    BUS_rready = 1'b1;
    @(posedge clk); #1;
    chk(!BUS_rvalid, "rvalid_clear", {31'd0, BUS_rvalid}, 32'd0);
    chk(busy, "busy_in_release", {31'd0, busy}, 32'd1);
    chk(BUS_rdata === exp_data, "rdata_held", BUS_rdata, exp_data);
    BUS_valid = 1'b0; BUS_rready = 1'b0;
    @(posedge clk); #1;
    chk(!busy, "busy_after_read", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1;
    chk(BUS_wready == 1'b0, "reset_wready", {31'd0, BUS_wready}, 32'd0);
    chk(BUS_rvalid == 1'b0, "reset_rvalid", {31'd0, BUS_rvalid}, 32'd0);
    chk(BUS_rdata == 32'd0, "reset_rdata", BUS_rdata, 32'd0);
    chk(busy == 1'b0, "reset_busy", {31'd0, busy}, 32'd0);
    chk(err == 1'b0, "reset_err", {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_write(32'h0000_0010, 32'hCAFE_BABE, 1'b0, 0);
    do_read(32'h0000_0010, 32'hCAFE_BABE, 1'b0, 5);

    do_write(32'h0000_0FFC, 32'h0BAD_F00D, 1'b0, 10);
    do_read(32'h0000_3FFC, 32'h0BAD_F00D, 1'b0, 0);

    do_write(32'h0000_1004, 32'h1234_5678, 1'b0, 0);
    do_read(32'h0000_0004, 32'h1234_5678, 1'b0, 1);

    // Interrupted write: old value must survive the async reset.
    do_write(32'h0000_0040, 32'hA5A5_0001, 1'b0, 0);
    do_read(32'h0000_0040, 32'hA5A5_0001, 1'b0, 0);
    BUS_valid = 1'b1; BUS_mode = 1'b1; BUS_addr = 32'h0000_0040; BUS_wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk(!busy, "midreset_busy", {31'd0, busy}, 32'd0);
    chk(!BUS_wready && !BUS_rvalid, "midreset_handshake", {30'd0, BUS_wready, BUS_rvalid}, 32'd0);
    chk(BUS_rdata == 32'd0, "midreset_rdata", BUS_rdata, 32'd0);
    BUS_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(32'h0000_0040, 32'hA5A5_0001, 1'b0, 0);

    do_write(32'h0000_0020, 32'h55AA_0000, 1'b0, 0);
`ifdef BUS_MEM_ALIGN_CHECK_EN
    do_write(32'h0000_0022, 32'h0000_0001, 1'b1, 0);
    do_read(32'h0000_0020, 32'h55AA_0000, 1'b0, 0);
    do_read(32'h0000_0021, 32'hDEAD_BEEF, 1'b1, 3);
`else
    do_write(32'h0000_0022, 32'h0000_0001, 1'b0, 0);
    do_read(32'h0000_0020, 32'h0000_0001, 1'b0, 0);
    do_read(32'h0000_0021, 32'h0000_0001, 1'b0, 3);
`endif

    repeat (5) @(negedge clk);
    chk(sb.size() == 0, "scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
